// File: rtl/mips_fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, fetches over a req/ready handshake,
// holds the instruction for one execute window and resolves branch/jump targets.
module mips_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32,
   parameter int          MAX_WAIT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             branch,
   input  logic             pc_src,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_rdata,
   input  logic             imem_ready,
   output logic [31:0]      instr,
   output logic [5:0]       opcode,
   output logic [5:0]       funct,
   output logic             instr_valid,
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus4,
   output logic [CNT_W-1:0] retired_count,
   output logic             fetch_err
);

   // state   | meaning
   // S_BOOT  | one idle cycle after reset release
   // S_FETCH | request outstanding at pc, waiting for imem_ready
   // S_EXEC  | instr live for the control unit, waits for stall=0
   // S_HALT  | memory timeout, frozen until reset
   typedef enum logic [1:0] {S_BOOT, S_FETCH, S_EXEC, S_HALT} state_t;

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t      state;
   logic [7:0]  wait_cnt;
   logic [31:0] br_off;
   logic [31:0] next_pc;

   assign imem_addr = pc;
   assign pc_plus4  = pc + 32'd4;
   assign opcode    = instr[31:26];
   assign funct     = instr[5:0];
   assign br_off    = {{14{instr[15]}}, instr[15:0], 2'b00};

   always_comb begin
      next_pc = pc_plus4;
      if (pc_src)
         next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      else if (branch)
         next_pc = pc_plus4 + br_off;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_BOOT;
         pc            <= RESET_PC;
         instr         <= 32'h0;
         instr_valid   <= 1'b0;
         imem_req      <= 1'b0;
         retired_count <= '0;
         fetch_err     <= 1'b0;
         wait_cnt      <= 8'd0;
      end else begin
         case (state)
            S_BOOT: begin
               imem_req <= 1'b1;
               state    <= S_FETCH;
            end
            S_FETCH: begin
               if (imem_ready) begin
                  instr       <= imem_rdata;
                  wait_cnt    <= 8'd0;
                  imem_req    <= 1'b0;
                  instr_valid <= 1'b1;
                  state       <= S_EXEC;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
                  // this cycle is the MAX_WAIT-th one without ready
                  if (wait_cnt == WAIT_LAST) begin
                     fetch_err <= 1'b1;
                     imem_req  <= 1'b0;
                     state     <= S_HALT;
                  end
               end
            end
            S_EXEC: begin
               if (!stall) begin
                  pc            <= next_pc;
                  retired_count <= retired_count + CNT_W'(1);
                  instr_valid   <= 1'b0;
                  imem_req      <= 1'b1;
                  state         <= S_FETCH;
               end
            end
            S_HALT: begin
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
            end
            default: state <= S_HALT;
         endcase
      end
   end

   // a misaligned RESET_PC keeps its low bits through sequential fetch
   a_pc_aligned: assert property (@(posedge clk) disable iff (rst) pc[1:0] == 2'b00);

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_mips_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          MAX_WAIT = 15;
   localparam logic [31:0] ADDI     = 32'h2008_0001;
   localparam logic [31:0] BEQ_M2   = 32'h1000_FFFE;
   localparam logic [31:0] JMP_100  = 32'h0800_0040;
   localparam int PH_BOOT = 0, PH_FETCH = 1, PH_EXEC = 2, PH_HALT = 3;

   logic        clk = 1'b0;
   logic        rst, stall, branch, pc_src, imem_ready;
   logic [31:0] imem_rdata;
   logic        imem_req, instr_valid, fetch_err;
   logic [31:0] imem_addr, instr, pc, pc_plus4, retired_count;
   logic [5:0]  opcode, funct;

   int checks = 0;
   int errors = 0;

   mips_fetch_unit #(.RESET_PC(RESET_PC), .CNT_W(32), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst(rst), .stall(stall), .branch(branch), .pc_src(pc_src),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .imem_ready(imem_ready), .instr(instr), .opcode(opcode), .funct(funct),
      .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
      .retired_count(retired_count), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   // behavioural model: phase of the instruction's life plus architectural state
   int          m_ph;
   int          m_wait;
   logic [31:0] m_pc, m_instr, m_cnt;
   logic        m_err;

   function automatic logic [31:0] model_next(logic [31:0] cur_pc, logic [31:0] w,
                                              logic j, logic b);
      logic [31:0] seq;
      int          imm;
      seq = cur_pc + 32'd4;
      if (j) return {seq[31:28], w[25:0], 2'b00};
      if (b) begin
         imm = int'($signed(w[15:0]));
         return seq + 32'(imm * 4);
      end
      return seq;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ph = PH_BOOT; m_pc = RESET_PC; m_instr = 32'h0; m_cnt = 32'h0;
         m_err = 1'b0; m_wait = 0;
      end else begin
         case (m_ph)
            PH_BOOT: m_ph = PH_FETCH;
            PH_FETCH: begin
               if (imem_ready) begin
                  m_instr = imem_rdata; m_wait = 0; m_ph = PH_EXEC;
               end else begin
                  m_wait = m_wait + 1;
                  if (m_wait == MAX_WAIT) begin m_err = 1'b1; m_ph = PH_HALT; end
               end
            end
            PH_EXEC: begin
               if (!stall) begin
                  m_pc  = model_next(m_pc, m_instr, pc_src, branch);
                  m_cnt = m_cnt + 32'd1;
                  m_ph  = PH_FETCH;
               end
            end
            default: ;
         endcase
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // advance to the next falling edge and compare every output with the model
   task automatic tick();
      @(negedge clk);
      chk("imem_req", 32'(imem_req), 32'(m_ph == PH_FETCH));
      chk("imem_addr", imem_addr, m_pc);
      chk("pc", pc, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("instr", instr, m_instr);
      chk("opcode", 32'(opcode), 32'(m_instr[31:26]));
      chk("funct", 32'(funct), 32'(m_instr[5:0]));
      chk("instr_valid", 32'(instr_valid), 32'(m_ph == PH_EXEC));
      chk("retired_count", retired_count, m_cnt);
      chk("fetch_err", 32'(fetch_err), 32'(m_err));
   endtask

   // entered at a falling edge in FETCH; leaves at the falling edge of the next FETCH
   task automatic do_instr(input logic [31:0] w, input logic br, input logic ps,
                           input int nstall, input int ndelay);
      logic [31:0] a0, c0;
      a0 = imem_addr;
      c0 = retired_count;
      chk("fetch_req", 32'(imem_req), 32'd1);
      imem_ready = 1'b0;
      repeat (ndelay) begin
         tick();
         chk("wait_req", 32'(imem_req), 32'd1);
         chk("wait_addr", imem_addr, a0);
      end
      imem_ready = 1'b1; imem_rdata = w;
      tick();
      chk("exec_valid", 32'(instr_valid), 32'd1);
      chk("exec_instr", instr, w);
      imem_ready = 1'b0; branch = br; pc_src = ps; stall = (nstall > 0);
      repeat (nstall) begin
         tick();
         chk("stall_pc", pc, a0);
         chk("stall_count", retired_count, c0);
         chk("stall_valid", 32'(instr_valid), 32'd1);
      end
      stall = 1'b0;
      tick();
      chk("retire_count", retired_count, c0 + 32'd1);
      branch = 1'b0; pc_src = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b1; stall = 1'b0; branch = 1'b0; pc_src = 1'b0;
      imem_ready = 1'b0; imem_rdata = 32'h0;
      repeat (2) tick();
      chk("rst_pc", pc, RESET_PC);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_count", retired_count, 32'd0);
      chk("rst_err", 32'(fetch_err), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      rst = 1'b0;

      // back-to-back single-cycle fetches
      imem_ready = 1'b1; imem_rdata = ADDI;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (i % 2 == 0) begin
            chk("seq_addr", imem_addr, 32'(4 * (i / 2)));
            chk("seq_valid_lo", 32'(instr_valid), 32'd0);
         end else begin
            chk("seq_valid_hi", 32'(instr_valid), 32'd1);
         end
      end
      imem_ready = 1'b0;
      tick();
      chk("seq_count4", retired_count, 32'd4);
      chk("seq_pc", imem_addr, 32'h10);

      do_instr(BEQ_M2, 1'b1, 1'b0, 0, 0);
      chk("br_taken", imem_addr, 32'h0C);
      do_instr(ADDI, 1'b0, 1'b0, 0, 0);
      chk("br_seq", imem_addr, 32'h10);
      do_instr(BEQ_M2, 1'b0, 1'b0, 0, 0);
      chk("br_not_taken", imem_addr, 32'h14);
      do_instr(JMP_100, 1'b0, 1'b1, 0, 0);
      chk("jump", imem_addr, 32'h100);
      do_instr(JMP_100, 1'b1, 1'b1, 0, 0);
      chk("jump_prio", imem_addr, 32'h100);
      do_instr(ADDI, 1'b0, 1'b0, 2, 3);
      chk("wait_stall_addr", imem_addr, 32'h104);
      chk("wait_stall_count", retired_count, 32'd10);

      // memory never answers
      imem_ready = 1'b0;
      n = 0;
      while (!fetch_err && n < 40) begin
         tick();
         n++;
      end
      chk("timeout_cycles", 32'(n), 32'd15);
      chk("halt_req", 32'(imem_req), 32'd0);
      repeat (3) tick();
      chk("halt_pc", pc, 32'h104);
      chk("halt_err", 32'(fetch_err), 32'd1);
      rst = 1'b1;
      #1;
      chk("rerst_err", 32'(fetch_err), 32'd0);
      chk("rerst_pc", pc, RESET_PC);
      tick();
      rst = 1'b0;
      tick();

      // branch below zero wraps, then pc_plus4 wraps back to zero
      do_instr(BEQ_M2, 1'b1, 1'b0, 0, 0);
      chk("wrap_pc", pc, 32'hFFFF_FFFC);
      chk("wrap_pc4", pc_plus4, 32'h0);
      do_instr(ADDI, 1'b0, 1'b0, 0, 0);
      chk("wrap_back", pc, 32'h0);

      // asynchronous reset while a request is outstanding
      do_instr(ADDI, 1'b0, 1'b0, 0, 1);
      chk("pre_async_pc", pc, 32'h4);
      #2 rst = 1'b1;
      #1;
      chk("async_req", 32'(imem_req), 32'd0);
      chk("async_pc", pc, RESET_PC);
      imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick();
      rst = 1'b0;
      tick();
      chk("late_ready_instr", instr, 32'h0);
      chk("late_ready_req", 32'(imem_req), 32'd1);
      imem_ready = 1'b0;

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         imem_rdata = $urandom;
         imem_ready = ($urandom_range(0, 3) != 0);
         stall      = ($urandom_range(0, 3) == 0);
         branch     = 1'($urandom_range(0, 1));
         pc_src     = ($urandom_range(0, 3) == 0);
         if (i % 200 == 100) imem_ready = 1'b0;
         if ($urandom_range(0, 99) == 0 || fetch_err) begin
            #2 rst = 1'b1;
         end
         tick();
         rst = 1'b0;
      end
      // a long ready-low burst driven from random traffic must also time out
      imem_ready = 1'b0; stall = 1'b0;
      repeat (20) tick();
      chk("rand_timeout", 32'(fetch_err), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the MIPS control unit.
- Holds the PC and fetches a word from instruction memory over a req/ready handshake, then latches it into an instruction register.
- Presents the latched instruction to the control unit (opcode) and the ALU controller (funct) for one execute window.
- Computes the next PC from the control unit's branch/jump decisions. Also counts retired instructions and flags instruction-memory timeouts.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.
- MAX_WAIT, 15, maximum wait cycles for imem_ready before a fetch error (1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- stall  in  1  hold the current instruction in EXEC (no PC update).
- branch  in  1  control-unit Branch (already gated by zero); sampled only in EXEC.
- pc_src  in  1  control-unit PCSrc (jump); sampled only in EXEC.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, equal to pc.
- imem_rdata  in  32  fetched word; valid when imem_ready=1.
- imem_ready  in  1  memory accepts and returns the word this cycle.
- instr  out  32  instruction register.
- opcode  out  6  instr[31:26], to the control unit.
- funct  out  6  instr[5:0], to the ALU controller.
- instr_valid  out  1  instr is live (EXEC state).
- pc  out  32  current PC.
- pc_plus4  out  32  pc+4, combinational.
- retired_count  out  CNT_W  instructions completed.
- fetch_err  out  1  sticky imem timeout flag.

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous and active-high.
- Reset values: pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, retired_count=0, fetch_err=0, wait counter=0, state=BOOT. Reset asserted mid-fetch drops imem_req immediately (asynchronously); any in-flight memory response is discarded.
- BOOT: one cycle after reset release, imem_req=0. Goes to FETCH.
- FETCH:
  - imem_req=1 and imem_addr=pc; both held stable until imem_ready.
  - On imem_ready=1: instr<=imem_rdata, wait counter cleared, go to EXEC. instr_valid=1 from the next cycle.
  - Otherwise the wait counter increments. When it reaches MAX_WAIT with ready still low: fetch_err<=1, go to HALT.
  - Minimum fetch latency: ready in the first FETCH cycle gives 1 cycle FETCH + 1 cycle EXEC.
- EXEC:
  - imem_req=0, instr_valid=1; opcode/funct drive the control unit combinationally.
  - If stall=1: stay in EXEC; pc, instr and count are unchanged.
  - If stall=0: pc<=next_pc, retired_count<=retired_count+1 (wraps modulo 2^CNT_W), instr_valid<=0, go to FETCH.
- next_pc:
  - Priority: pc_src over branch over sequential.
  - Jump: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - Branch: pc_plus4 + (sign_extend(instr[15:0]) << 2). 32-bit wrap-around; no overflow detection.
  - Otherwise: pc_plus4.
  - pc_plus4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- HALT: imem_req=0, instr_valid=0, pc frozen, fetch_err=1. Exits only via rst.
- branch and pc_src are ignored outside EXEC. If both are asserted together, the jump wins.
- pc[1:0] is always 2'b00 provided RESET_PC is word-aligned. A RESET_PC with nonzero [1:0] is illegal configuration and is flagged by an assertion.

Test Plan:
- Sequential fetch: reset, RESET_PC=0, memory ready in 1 cycle returning ADDI words. Required: imem_addr sequence 0,4,8,12; instr_valid high every other cycle; retired_count=4 after 8 cycles.
- Taken branch: instr at pc=0x10 is 32'h1000_FFFE (BEQ, imm=-2), branch=1 in EXEC. Required: next imem_addr=0x0C (0x14-8). With branch=0 instead: next imem_addr=0x14.
- Jump priority: instr 32'h0800_0040 at pc=0x100, pc_src=1 and branch=1 together. Required: next imem_addr=0x0000_0100 (jump target, branch ignored).
- Memory wait and stall: imem_ready delayed 3 cycles, then stall held 2 cycles in EXEC. Required: imem_req and imem_addr stable through the wait; pc and retired_count unchanged during the stall; advance on the first stall=0 cycle.
- Timeout: MAX_WAIT=15, imem_ready never asserted. Required: fetch_err=1 on the 15th wait cycle edge; state HALT with imem_req=0. Then assert rst: fetch_err=0, pc=RESET_PC, fetch restarts.
- Async reset mid-fetch: assert rst between clock edges while imem_req=1. Required: imem_req=0 and pc=RESET_PC immediately without a clock edge; a late imem_ready after release is ignored during BOOT.
